// File: rtl/alu_mc.sv
// Multi-cycle RV32IM-style ALU: single-cycle RV32I ops plus iterative
// shift-add multiply and restoring divide behind a valid/ready handshake.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_alucontrol,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero
);

  // state | meaning
  // IDLE  | ready; single-cycle ops and divide early-outs complete here
  // BUSY  | one radix-2 multiply/divide step per cycle until cnt hits 0
  typedef enum logic {IDLE, BUSY} state_t;

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [3:0]           op_q, op_nxt;
  logic [WIDTH-1:0]     opb_q, opb_nxt;
  logic [2*WIDTH-1:0]   acc, acc_nxt, acc_step;
  logic                 neg_q, neg_q_nxt, neg_r, neg_r_nxt;
  logic                 valid_nxt, load_res;
  logic [WIDTH-1:0]     result_nxt, alu_res, early_res, iter_res;
  logic [WIDTH-1:0]     min_val, a_mag, b_mag, quo, rem;
  logic [SW-1:0]        shamt;
  logic                 accept, is_iter, is_div, is_sdiv, div0, ovf, early;
  logic [WIDTH:0]       sum, shifted, diff;

  assign o_ready = (state == IDLE);
  assign accept  = i_valid & o_ready & ~i_flush;
  assign shamt   = i_b[SW-1:0];
  assign min_val = {1'b1, {(WIDTH-1){1'b0}}};

  assign is_iter = i_alucontrol[3] & (i_alucontrol[2] | i_alucontrol[1]);
  assign is_div  = i_alucontrol[3] & i_alucontrol[2];
  assign is_sdiv = is_div & ~i_alucontrol[0];
  assign div0    = (i_b == '0);
  assign ovf     = is_sdiv & (i_a == min_val) & (i_b == '1);
  assign early   = is_div & (div0 | ovf);
  assign a_mag   = (is_sdiv & i_a[WIDTH-1]) ? -i_a : i_a;
  assign b_mag   = (is_sdiv & i_b[WIDTH-1]) ? -i_b : i_b;

  // Divide early-outs: bit 1 of the opcode selects remainder over quotient.
  always_comb begin
    early_res = '0;
    if (div0) early_res = i_alucontrol[1] ? i_a : '1;
    else if (ovf) early_res = i_alucontrol[1] ? '0 : min_val;
  end

  always_comb begin
    alu_res = early_res;
    case (i_alucontrol)
      4'b0000: alu_res = i_a + i_b;
      4'b0001: alu_res = i_a - i_b;
      4'b0010: alu_res = i_a & i_b;
      4'b0011: alu_res = i_a | i_b;
      4'b0100: alu_res = i_a ^ i_b;
      4'b0101: alu_res = {{(WIDTH-1){1'b0}}, $signed(i_a) < $signed(i_b)};
      4'b0110: alu_res = {{(WIDTH-1){1'b0}}, i_a < i_b};
      4'b0111: alu_res = i_a << shamt;
      4'b1000: alu_res = i_a >> shamt;
      4'b1001: alu_res = $signed(i_a) >>> shamt;
      default: alu_res = early_res;
    endcase
  end

  assign sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
  assign shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign diff    = shifted - {1'b0, opb_q};

  always_comb begin
    acc_step = {1'b0, acc[2*WIDTH-1:1]};
    if (op_q[2]) begin
      if (!diff[WIDTH]) acc_step = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else              acc_step = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else if (acc[0]) begin
      acc_step = {sum, acc[WIDTH-1:1]};
    end
  end

  assign quo = acc_step[WIDTH-1:0];
  assign rem = acc_step[2*WIDTH-1:WIDTH];

  always_comb begin
    iter_res = rem;
    case (op_q)
      4'b1010: iter_res = quo;
      4'b1011: iter_res = rem;
      4'b1100: iter_res = neg_q ? -quo : quo;
      4'b1101: iter_res = quo;
      4'b1110: iter_res = neg_r ? -rem : rem;
      default: iter_res = rem;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    op_nxt     = op_q;
    opb_nxt    = opb_q;
    acc_nxt    = acc;
    neg_q_nxt  = neg_q;
    neg_r_nxt  = neg_r;
    valid_nxt  = 1'b0;
    load_res   = 1'b0;
    result_nxt = o_result;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_iter & ~early) begin
            state_nxt = BUSY;
            cnt_nxt   = CW'(WIDTH);
            op_nxt    = i_alucontrol;
            opb_nxt   = is_div ? b_mag : i_b;
            acc_nxt   = {{WIDTH{1'b0}}, (is_div ? a_mag : i_a)};
            neg_q_nxt = i_a[WIDTH-1] ^ i_b[WIDTH-1];
            neg_r_nxt = i_a[WIDTH-1];
          end else begin
            valid_nxt  = 1'b1;
            load_res   = 1'b1;
            result_nxt = alu_res;
          end
        end
      end
      BUSY: begin
        if (i_flush) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          acc_nxt = acc_step;
          cnt_nxt = cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state_nxt  = IDLE;
            valid_nxt  = 1'b1;
            load_res   = 1'b1;
            result_nxt = iter_res;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= '0;
      opb_q    <= '0;
      acc      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      o_valid  <= 1'b0;
      o_result <= '0;
      o_zero   <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      op_q    <= op_nxt;
      opb_q   <= opb_nxt;
      acc     <= acc_nxt;
      neg_q   <= neg_q_nxt;
      neg_r   <= neg_r_nxt;
      o_valid <= valid_nxt;
      if (load_res) begin
        o_result <= result_nxt;
        o_zero   <= (result_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed + random bench for alu_mc with a latency-tagged scoreboard.
module tb_alu_mc;
  localparam int W  = 32;
  localparam int SW = $clog2(W);

  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, SLT = 4'b0101, SLTU = 4'b0110,
                         SRA = 4'b1001, MUL = 4'b1010, MULHU = 4'b1011, DIV = 4'b1100,
                         DIVU = 4'b1101, REM = 4'b1110, REMU = 4'b1111;

  logic         clk = 1'b0, rst_n = 1'b0, valid = 1'b0, flush = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [3:0]   ctl = '0;
  logic         ready, ovalid, zero;
  logic [W-1:0] res;

  alu_mc #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready), .i_flush(flush),
    .i_a(a), .i_b(b), .i_alucontrol(ctl), .o_valid(ovalid), .o_result(res), .o_zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    int           due;
    string        tag;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           n_cmp = 0, n_bad = 0;
  logic [W-1:0] last_r = '0;
  logic [W-1:0] min_v, ones_v;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [W-1:0] sx, sy;
    logic [2*W-1:0]      p;
    logic [W-1:0]        mn;
    logic [SW-1:0]       sh;
    sx = x; sy = y;
    mn = '0; mn[W-1] = 1'b1;
    sh = y[SW-1:0];
    p  = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    case (op)
      4'd0:  return x + y;
      4'd1:  return x - y;
      4'd2:  return x & y;
      4'd3:  return x | y;
      4'd4:  return x ^ y;
      4'd5:  return (sx < sy) ? W'(1) : W'(0);
      4'd6:  return (x < y) ? W'(1) : W'(0);
      4'd7:  return x << sh;
      4'd8:  return x >> sh;
      4'd9:  return sx >>> sh;
      4'd10: return p[W-1:0];
      4'd11: return p[2*W-1:W];
      4'd12: begin
        if (y == '0) return '1;
        if (x == mn && y == '1) return mn;
        return sx / sy;
      end
      4'd13: return (y == '0) ? '1 : x / y;
      4'd14: begin
        if (y == '0) return x;
        if (x == mn && y == '1) return '0;
        return sx % sy;
      end
      default: return (y == '0) ? x : x % y;
    endcase
  endfunction

  function automatic bit multi(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] mn;
    mn = '0; mn[W-1] = 1'b1;
    if (op < 4'd10) return 1'b0;
    if (op >= 4'd12 && (y == '0 || (!op[0] && x == mn && y == '1))) return 1'b0;
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1 && ovalid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", W'(ovalid), W'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, "_result"}, res, e.r);
        chk({e.tag, "_zero"}, W'(zero), W'(e.r == '0));
        chk({e.tag, "_latency"}, W'(cyc), W'(e.due));
        last_r = e.r;
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit push, input string tag, output int waited);
    exp_t e;
    waited = 0;
    @(negedge clk);
    while (ready !== 1'b1 && waited < 4*W + 16) begin
      waited++;
      @(negedge clk);
    end
    if (ready !== 1'b1) chk({tag, "_ready_timeout"}, W'(ready), W'(1));
    ctl = op; a = x; b = y; valid = 1'b1;
    if (push) begin
      e.r   = model(op, x, y);
      e.due = cyc + (multi(op, x, y) ? W + 1 : 1);
      e.tag = tag;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 4*W + 16) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drained"}, W'(sb.size()), W'(0));
  endtask

  initial begin
    int   w;
    exp_t e;
    min_v = '0; min_v[W-1] = 1'b1;
    ones_v = '1;

    rst_n = 1'b0; valid = 1'b1; ctl = ADD; a = W'(3); b = W'(4);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", W'(ovalid), W'(0));
    chk("rst_result", res, W'(0));
    chk("rst_zero", W'(zero), W'(1));
    chk("rst_ready", W'(ready), W'(1));
    rst_n = 1'b1;
    e.r = W'(7); e.due = cyc + 1; e.tag = "first_after_rst";
    sb.push_back(e);
    @(posedge clk);
    #1 valid = 1'b0;

    issue(SUB, W'(5), W'(5), 1'b1, "sub", w);       chk("b2b_ready_sub", W'(w), W'(0));
    issue(SLT, ones_v, W'(1), 1'b1, "slt", w);      chk("b2b_ready_slt", W'(w), W'(0));
    issue(SLTU, ones_v, W'(1), 1'b1, "sltu", w);    chk("b2b_ready_sltu", W'(w), W'(0));
    issue(SRA, min_v, W'(36), 1'b1, "sra", w);      chk("b2b_ready_sra", W'(w), W'(0));

    issue(MULHU, ones_v, ones_v, 1'b1, "mulhu", w);
    issue(MUL, W'(32'h0001_0003), W'(5), 1'b1, "mul", w);
    chk("mul_ready_low_cycles", W'(w), W'(W));

    issue(DIV, -W'(7), W'(2), 1'b1, "div", w);
    issue(REM, -W'(7), W'(2), 1'b1, "rem", w);
    issue(DIVU, W'(100), W'(7), 1'b1, "divu", w);
    issue(REMU, W'(100), W'(7), 1'b1, "remu", w);
    issue(DIVU, W'(7), W'(0), 1'b1, "divu_by0", w);
    issue(REMU, W'(7), W'(0), 1'b1, "remu_by0", w);
    issue(DIV, -W'(9), W'(0), 1'b1, "div_by0", w);
    issue(REM, -W'(9), W'(0), 1'b1, "rem_by0", w);
    issue(DIV, min_v, ones_v, 1'b1, "div_ovf", w);
    issue(REM, min_v, ones_v, 1'b1, "rem_ovf", w);
    issue(ADD, W'(1), W'(2), 1'b1, "add", w);
    drain("directed");

    issue(DIV, W'(100), W'(7), 1'b0, "flush_div", w);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    a = W'(55); b = W'(3);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_ready", W'(ready), W'(1));
    chk("flush_valid", W'(ovalid), W'(0));
    chk("flush_result_kept", res, last_r);
    chk("flush_zero_kept", W'(zero), W'(last_r == '0));
    repeat (W + 4) @(negedge clk);

    issue(DIVU, W'(100), W'(7), 1'b0, "rst_div", w);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", W'(ready), W'(1));
    chk("midrst_valid", W'(ovalid), W'(0));
    chk("midrst_result", res, W'(0));
    chk("midrst_zero", W'(zero), W'(1));
    last_r = '0;
    repeat (W + 4) @(negedge clk);

    @(negedge clk);
    valid = 1'b1; flush = 1'b1; ctl = ADD; a = W'(1); b = W'(1);
    @(posedge clk);
    #1 begin valid = 1'b0; flush = 1'b0; end
    @(negedge clk);
    chk("idle_flush_valid", W'(ovalid), W'(0));
    chk("idle_flush_result", res, W'(0));

    for (int i = 0; i < 24; i++) begin
      logic [3:0]   rop;
      logic [W-1:0] ra, rb;
      rop = 4'($urandom_range(0, 15));
      ra  = W'({$urandom, $urandom});
      rb  = ($urandom_range(0, 7) == 0) ? '0 : W'({$urandom, $urandom});
      issue(rop, ra, rb, 1'b1, "rand", w);
    end
    drain("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU: the next generation of the execute-stage ALU, widened to the full RV32IM integer operation set. Single-cycle RV32I arithmetic, logic, compare and shift operations complete in one cycle. Iterative multiply and divide/remainder (M extension) run for WIDTH cycles behind a valid/ready handshake. The block sits in the execute stage between operand selection and the writeback register.

## Interface

**Parameters**
- WIDTH, 32: operand/result width. Must be a power of two, ≥ 8.

**Ports**
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_valid  input  1  operation request; sampled only when o_ready = 1.
- o_ready  output  1  block can accept a request this cycle.
- i_flush  input  1  abort any in-flight operation; overrides i_valid.
- i_a  input  WIDTH  operand A.
- i_b  input  WIDTH  operand B.
- i_alucontrol  input  4  operation select:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
  - 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA
  - 1010 MUL, 1011 MULHU, 1100 DIV, 1101 DIVU, 1110 REM, 1111 REMU
- o_valid  output  1  one-cycle pulse; o_result and o_zero are valid.
- o_result  output  WIDTH  registered result; held until the next completion.
- o_zero  output  1  registered, set when o_result == 0; updated together with o_result.

## Operation

**States**
- IDLE
  - o_ready = 1.
  - Accept fires when i_valid & o_ready & !i_flush.
  - A single-cycle op (codes 0000–1001) is computed combinationally and registered into o_result with o_valid = 1 next cycle. State stays IDLE.
  - MUL/MULHU/DIV/DIVU/REM/REMU latch the operands and opcode, load the iteration counter with WIDTH, and go to BUSY.
- BUSY
  - o_ready = 0.
  - Each cycle performs one radix-2 step:
    - Multiply: shift-add on a 2·WIDTH-bit product.
    - Divide: restoring shift-subtract on a WIDTH-bit remainder/quotient.
  - Counter decrements each step. When it reaches 0, the final result is written to o_result, o_valid pulses, and the state returns to IDLE.

**Arithmetic rules**
- All add/sub results wrap modulo 2^WIDTH.
- SLT compares signed; SLTU compares unsigned. Result is 1 or 0, zero-extended.
- Shift amount is i_b[$clog2(WIDTH)-1:0]; upper bits of i_b are ignored. SRA replicates the sign bit.
- MUL returns product[WIDTH-1:0]. MULHU returns the unsigned product[2·WIDTH-1:WIDTH].
- DIV/REM (signed):
  - Operands are converted to magnitudes, divided unsigned, then corrected.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - Truncation is toward zero.

**Boundary conditions (RISC-V defined, no exceptions)**
- Divisor 0:
  - Quotient = all ones. Remainder = dividend.
  - Early-out: completes as a single-cycle op, with no BUSY state.
- Signed overflow (DIV of the most-negative value by −1):
  - Quotient = most-negative value. Remainder = 0.
  - Early-out: single-cycle.
- i_flush in BUSY: return to IDLE next cycle. No o_valid. o_result and o_zero keep their previous values.
- i_flush in IDLE with i_valid: request not accepted, no o_valid.
- Reset asserted mid-operation: identical to flush, plus all outputs return to their reset values.
- Operand inputs may change while in BUSY; only the values latched at accept are used.

## Timing

**Reset values**
- IDLE state, o_ready = 1, o_valid = 0, o_result = 0, o_zero = 1, counter = 0.

**Latency** (accept at cycle t)
- Single-cycle ops and early-outs: o_valid at t+1.
- Iterative ops: o_valid at t+WIDTH+1, i.e. t+33 at WIDTH = 32.

**Throughput and readiness**
- Single-cycle ops: one per cycle, back-to-back.
- After an iterative accept, o_ready is low from t+1 through t+WIDTH. It returns high in the o_valid cycle, so a new request can be accepted in the same cycle a multi-cycle result is presented.

**Outputs**
- o_valid is exactly one cycle wide per accepted, unflushed request.
- o_result and o_zero are stable between pulses.

## Test plan

- **Reset.** Hold i_rst_n = 0 for 2 cycles with i_valid = 1 → o_valid = 0, o_result = 0, o_zero = 1, o_ready = 1. Release reset → the first request is accepted.
- **Back-to-back single-cycle ops.** SUB 5−5, then SLT 0xFFFFFFFF vs 1, then SLTU same operands, then SRA 0x80000000 by 0x24 → results 0 (o_zero = 1), 1, 0, 0xF8000000 on consecutive cycles. o_ready is high throughout.
- **Multiply.** MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE at t+33; o_ready is low for cycles t+1..t+32. Then MUL 0x0001_0003 × 0x0000_0005 → 0x0005_000F.
- **Signed divide.** DIV −7 / 2 → 0xFFFFFFFD. REM −7 / 2 → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2. Each completes at t+33.
- **Divide corner cases.** DIVU 7 / 0 → 0xFFFFFFFF at t+1. REMU 7 / 0 → 7. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM of the same operands → 0 with o_zero = 1.
- **Abort and parameter sweep.** Start DIV, assert i_flush at t+10 → no o_valid, o_ready = 1 at t+11, previous o_result retained. Repeat with i_rst_n low at t+10 → outputs at reset values. Re-run the whole suite with WIDTH = 8 and WIDTH = 64.
